// File: rtl/cra_pkg.sv
// Shared definitions for the CRAM microcode sequencer: next-address mode
// encoding and the default CRAM address width.
package cra_pkg;

  localparam int ADR_W_DEF = 11;

  typedef enum logic [2:0] {
    DISP_J    = 3'd0,
    DISP_OR   = 3'd1,
    DISP_SKIP = 3'd2,
    DISP_RET  = 3'd3,
    DISP_DRAM = 3'd4,
    DISP_DIAG = 3'd5
  } disp_e;

endpackage

// File: rtl/cra_rstack.sv
// Circular return-address LIFO with push, pop, replace-top, clear, depth and
// sticky overflow/underflow flags. Optional entry parity: CRA_STACK_PARITY_EN.
module cra_rstack
  import cra_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           clear_i,
  input  logic                           clr_err_i,
  input  logic [ADR_W-1:0]               push_val_i,
  output logic [ADR_W-1:0]               top_o,
  output logic [$clog2(STACK_DEPTH):0]   depth_o,
  output logic                           ovf_o,
`ifdef CRA_STACK_PARITY_EN
  output logic                           par_err_o,
`endif
  output logic                           unf_o
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;
`ifdef CRA_STACK_PARITY_EN
  localparam int EW = ADR_W + 1;
`else
  localparam int EW = ADR_W;
`endif

  logic [EW-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          set_ovf, set_unf, wr_en, empty, full;
  logic [EW-1:0] wr_data;

  assign top_idx = ptr_q - 1'b1;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign top_o   = empty ? '0 : mem_q[top_idx][ADR_W-1:0];
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

`ifdef CRA_STACK_PARITY_EN
  logic perr_q, perr_d, set_perr;
  // Odd parity: a healthy entry always has an odd number of ones.
  assign wr_data   = {~^push_val_i, push_val_i};
  assign set_perr  = pop_i & ~clear_i & ~empty & ~(^mem_q[top_idx]);
  assign perr_d    = (perr_q & ~clr_err_i) | set_perr;
  assign par_err_o = perr_q;
`else
  assign wr_data = push_val_i;
`endif

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (clear_i) begin
      depth_d = '0;
    end else if (push_i && pop_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (pop_i) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        ptr_d   = top_idx;
        depth_d = depth_q - 1'b1;
      end
    end else if (push_i) begin
      // When full the write slot is the oldest entry, so it is overwritten.
      wr_en = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (full) set_ovf = 1'b1;
      else      depth_d = depth_q + 1'b1;
    end
    ovf_d = (ovf_q & ~clr_err_i) | set_ovf;
    unf_d = (unf_q & ~clr_err_i) | set_unf;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef CRA_STACK_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef CRA_STACK_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/cra_useq.sv
// CRAM microcode sequencer: next-address mux, cradr register and CALL/RETURN
// control around cra_rstack. Optional stack parity: CRA_STACK_PARITY_EN.
module cra_useq
  import cra_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int STACK_DEPTH = 16,
  parameter int DISP_W      = 4
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         stall,
  input  logic                         force1777,
  input  logic [ADR_W-1:0]             j,
  input  logic [2:0]                   dispSel,
  input  logic [DISP_W-1:0]            dispIn,
  input  logic                         skipIn,
  input  logic                         call,
  input  logic [ADR_W-1:0]             dramJ,
  input  logic [ADR_W-1:0]             diagAdr,
  input  logic                         clrErr,
  output logic [ADR_W-1:0]             cradr,
  output logic [$clog2(STACK_DEPTH):0] stackDepth,
  output logic                         stackOverflow,
  output logic                         stackUnderflow,
`ifdef CRA_STACK_PARITY_EN
  output logic                         stackParityErr,
`endif
  output logic                         dispParity
);

  logic [ADR_W-1:0] cradr_q, cradr_d, top_val, ret_adr;
  logic             advance, is_ret, push, pop, clr_err;

  // force1777 overrides stall; with either active the stack sees no push/pop.
  assign advance = ~stall & ~force1777;
  assign is_ret  = (disp_e'(dispSel) == DISP_RET);
  assign push    = advance & call;
  assign pop     = advance & is_ret;
  assign clr_err = advance & clrErr;
  assign ret_adr = cradr_q + 1'b1;

  assign cradr      = cradr_q;
  assign dispParity = ^{call, dispSel};

  cra_rstack #(
    .ADR_W       (ADR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_rstack (
    .clk        (clk),
    .resetN     (resetN),
    .push_i     (push),
    .pop_i      (pop),
    .clear_i    (force1777),
    .clr_err_i  (clr_err),
    .push_val_i (ret_adr),
    .top_o      (top_val),
    .depth_o    (stackDepth),
    .ovf_o      (stackOverflow),
`ifdef CRA_STACK_PARITY_EN
    .par_err_o  (stackParityErr),
`endif
    .unf_o      (stackUnderflow)
  );

  always_comb begin
    cradr_d = cradr_q;
    if (force1777) begin
      cradr_d = '1;
    end else if (!stall) begin
      unique case (disp_e'(dispSel))
        DISP_OR:   cradr_d = j | ADR_W'(dispIn);
        DISP_SKIP: cradr_d = j | ADR_W'(skipIn);
        DISP_RET:  cradr_d = j | top_val;
        DISP_DRAM: cradr_d = dramJ;
        DISP_DIAG: cradr_d = diagAdr;
        default:   cradr_d = j;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cradr_q <= '0;
    else         cradr_q <= cradr_d;
  end

endmodule

// File: tb/tb_cra_useq.sv
// Scoreboard bench for cra_useq: a queue-based stack model predicts each
// cycle's cradr/depth/flags, a monitor compares after every rising edge.
module tb_cra_useq;

  localparam int AW = 11;
  localparam int SD = 16;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          resetN, stall, force1777, skipIn, call, clrErr;
  logic [AW-1:0] j, dramJ, diagAdr;
  logic [2:0]    dispSel;
  logic [DW-1:0] dispIn;
  logic [AW-1:0] cradr;
  logic [4:0]    stackDepth;
  logic          stackOverflow, stackUnderflow, dispParity;
`ifdef CRA_STACK_PARITY_EN
  logic          stackParityErr;
`endif

  cra_useq #(.ADR_W(AW), .STACK_DEPTH(SD), .DISP_W(DW)) dut (
    .clk(clk), .resetN(resetN), .stall(stall), .force1777(force1777),
    .j(j), .dispSel(dispSel), .dispIn(dispIn), .skipIn(skipIn), .call(call),
    .dramJ(dramJ), .diagAdr(diagAdr), .clrErr(clrErr), .cradr(cradr),
    .stackDepth(stackDepth), .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow),
`ifdef CRA_STACK_PARITY_EN
    .stackParityErr(stackParityErr),
`endif
    .dispParity(dispParity));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [4:0]    d;
    logic          o;
    logic          u;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [AW-1:0] m_cradr;
  logic [AW-1:0] m_stk[$];
  logic          m_ovf, m_unf;

  // Stimulus applied by the next tick
  logic          s_rst, s_stall, s_force, s_call, s_clr, s_skip;
  logic [2:0]    s_ds;
  logic [AW-1:0] s_j, s_dj, s_da;
  logic [DW-1:0] s_di;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic idle();
    s_rst = 0; s_stall = 0; s_force = 0; s_call = 0; s_clr = 0; s_skip = 0;
    s_ds = 3'd0; s_j = '0; s_dj = '0; s_da = '0; s_di = '0;
  endtask

  task automatic model_step();
    logic [AW-1:0] topv, nxt, ra;
    logic set_o, set_u;
    set_o = 0; set_u = 0;
    if (s_rst) begin
      m_cradr = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (s_force) begin
      m_cradr = '1; m_stk.delete();
    end else if (!s_stall) begin
      topv = (m_stk.size() > 0) ? m_stk[$] : '0;
      ra   = m_cradr + 1'b1;
      case (s_ds)
        3'd1:    nxt = s_j | {{(AW-DW){1'b0}}, s_di};
        3'd2:    nxt = s_j | {{(AW-1){1'b0}}, s_skip};
        3'd3:    nxt = s_j | topv;
        3'd4:    nxt = s_dj;
        3'd5:    nxt = s_da;
        default: nxt = s_j;
      endcase
      if (s_ds == 3'd3 && s_call) begin
        if (m_stk.size() > 0) m_stk[$] = ra;
      end else if (s_ds == 3'd3) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else set_u = 1;
      end else if (s_call) begin
        m_stk.push_back(ra);
        if (m_stk.size() > SD) begin
          void'(m_stk.pop_front());
          set_o = 1;
        end
      end
      m_ovf = (s_clr ? 1'b0 : m_ovf) | set_o;
      m_unf = (s_clr ? 1'b0 : m_unf) | set_u;
      m_cradr = nxt;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    resetN = ~s_rst; stall = s_stall; force1777 = s_force; call = s_call;
    clrErr = s_clr; skipIn = s_skip; dispSel = s_ds; j = s_j; dramJ = s_dj;
    diagAdr = s_da; dispIn = s_di;
    model_step();
    e.a = m_cradr; e.d = 5'(m_stk.size()); e.o = m_ovf; e.u = m_unf;
    exp_q.push_back(e);
    #1;
    chk("dispParity", {31'd0, dispParity}, $countones({s_call, s_ds}) % 2);
  endtask

  // Monitor: every rising edge yields one registered result to compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cradr", {21'd0, cradr}, {21'd0, e.a});
      chk("stackDepth", {27'd0, stackDepth}, {27'd0, e.d});
      chk("stackOverflow", {31'd0, stackOverflow}, {31'd0, e.o});
      chk("stackUnderflow", {31'd0, stackUnderflow}, {31'd0, e.u});
`ifdef CRA_STACK_PARITY_EN
      chk("stackParityErr", {31'd0, stackParityErr}, 32'd0);
`endif
    end
  end

  initial begin
    m_cradr = '0; m_ovf = 0; m_unf = 0;
    idle();
    resetN = 0; stall = 0; force1777 = 0; call = 0; clrErr = 0; skipIn = 0;
    dispSel = 0; j = '0; dramJ = '0; diagAdr = '0; dispIn = '0;
    #2;
    chk("reset_cradr", {21'd0, cradr}, 32'd0);
    chk("reset_depth", {27'd0, stackDepth}, 32'd0);
    chk("reset_flags", {30'd0, stackOverflow, stackUnderflow}, 32'd0);

    // Reset release: first edge loads j
    s_j = 11'h123; tick();
    // CALL at 0x100 then RETURN
    idle(); s_j = 11'h100; tick();
    idle(); s_call = 1; s_j = 11'h200; tick();
    idle(); s_ds = 3'd3; s_j = 11'h000; tick();
    // 17 distinct pushes then 16 pops
    idle(); tick();
    for (int i = 1; i <= 17; i++) begin
      idle(); s_call = 1; s_ds = 3'd5; s_da = AW'(i); tick();
    end
    for (int i = 0; i < 16; i++) begin
      idle(); s_ds = 3'd3; tick();
    end
    // Underflow, then clear the flags
    idle(); s_ds = 3'd3; s_j = 11'h040; tick();
    idle(); s_clr = 1; tick();
    // Stall holds everything, then force1777 during stall
    idle(); s_call = 1; s_j = 11'h055; tick();
    idle(); s_stall = 1; s_call = 1; s_ds = 3'd1; s_j = 11'h3F0; s_di = 4'hF; s_clr = 1; tick();
    idle(); s_stall = 1; s_force = 1; s_call = 1; tick();
    idle(); tick();

    // Randomized phases: push-heavy, then pop-heavy
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        idle();
        s_rst   = ($urandom_range(0, 299) == 0);
        s_stall = ($urandom_range(0, 7) == 0);
        s_force = ($urandom_range(0, 39) == 0);
        s_call  = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        s_clr   = ($urandom_range(0, 9) == 0);
        s_skip  = 1'($urandom);
        s_ds    = (ph == 1 && $urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom);
        s_j     = ($urandom_range(0, 1) == 0) ? '0 : AW'($urandom);
        s_dj    = AW'($urandom);
        s_da    = AW'($urandom);
        s_di    = DW'($urandom);
        tick();
      end
    end

    idle(); tick();
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cra_useq.md
Name: cra_useq

Overview:
- Parametrised successor to the CRAM address logic: a microcode sequencer for a CRAM of 2^ADR_W words.
- Each cycle it computes the next CRAM address from J, a selected dispatch or skip source, and a CALL/RETURN subroutine stack of configurable depth.
- The address is registered into cradr, which drives CRAM fetch in crm.
- It adds stall holding, a deep circular return stack with sticky overflow/underflow flags, force-1777 stack clear, and diagnostic address load.

Parameters:
ADR_W, 11, CRAM address width in bits.
STACK_DEPTH, 16, number of return-stack entries; must be a power of 2, at least 2.
DISP_W, 4, width of the dispatch field ORed into the low bits of J; must be at most ADR_W.

Ports:
clk  in  1  system clock; every state element updates on the rising edge.
resetN  in  1  asynchronous, active-low reset.
stall  in  1  hold cradr and the stack; all other inputs are ignored except force1777.
force1777  in  1  next address becomes all ones and the stack is cleared.
j  in  ADR_W  CRAM J field.
dispSel  in  3  next-address mode select; see Behaviour.
dispIn  in  DISP_W  dispatch data, e.g. DRAM A/B, SR, or NICOND.
skipIn  in  1  skip condition; ORed into bit 0 of J.
call  in  1  push the return address onto the stack.
dramJ  in  ADR_W  full DRAM J address.
diagAdr  in  ADR_W  diagnostic jump address.
clrErr  in  1  clear the sticky error flags.
cradr  out  ADR_W  registered current CRAM address.
stackDepth  out  $clog2(STACK_DEPTH)+1  number of valid stack entries.
stackOverflow  out  1  sticky flag: a push occurred while the stack was full.
stackUnderflow  out  1  sticky flag: a pop occurred while the stack was empty.
dispParity  out  1  even parity over {call, dispSel}, combinational.

Behaviour:
- Reset (resetN low, asynchronous): cradr=0, stack empty, stackDepth=0, both flags 0.
- Next-address selection by dispSel; the result is registered into cradr, with 1-cycle latency from input to cradr:
  - 0: j.
  - 1: j | zero-extended dispIn.
  - 2: j | skipIn.
  - 3 (RETURN): j | top of stack, then pop.
  - 4: dramJ.
  - 5: diagAdr.
  - 6 and 7: treated as 0.
- CALL:
  - When call=1 and the sequencer advances, push cradr+1 (modulo 2^ADR_W) onto the stack.
  - This is the address of the word after the CALL.
- CALL and RETURN in the same cycle:
  - The pop value is used for the address.
  - The pushed value replaces the top entry.
  - Depth is unchanged and no flags change.
- Stack is circular. Push when full:
  - The oldest entry is overwritten.
  - Depth stays at STACK_DEPTH.
  - stackOverflow is set.
- Pop when empty:
  - The OR value is 0, so cradr=j.
  - Depth stays at 0.
  - stackUnderflow is set.
- stall=1: cradr, stack, and depth are held. call and RETURN have no effect. The flags are held.
- force1777 (highest priority below reset; acts even during stall):
  - cradr becomes all ones on the next edge.
  - Depth becomes 0.
  - Stack contents are don't-care.
  - The flags are unaffected.
- clrErr clears both flags on the next edge. If a new error occurs in the same cycle, setting wins.
- Reset mid-operation discards all stack contents immediately.

Optional Feature:
- Macro CRA_STACK_PARITY_EN.
- When defined:
  - Each stack entry stores an extra odd-parity bit over the address, computed on push.
  - On pop, a mismatch sets the sticky output stackParityErr (1 bit, cleared by clrErr and by reset).
  - The popped value is still used.
- When not defined: the stackParityErr port and the parity storage are absent.

Decomposition:
- Shared package cra_pkg holds:
  - the dispSel encoding constants: DISP_J, DISP_OR, DISP_SKIP, DISP_RET, DISP_DRAM, DISP_DIAG;
  - the default ADR_W value.
- One natural sub-module, cra_rstack: a parametrised circular LIFO with push, pop, replace-top, clear, depth, and flag outputs, plus the optional parity.
- cra_useq contains the mux, the cradr register, and the control logic.

Test Plan:
- Release reset with dispSel=0, j=0x123 -> cradr=0x000 before the first edge, 0x123 after one edge.
- cradr=0x100, call=1, dispSel=0, j=0x200; next cycle dispSel=3, j=0 -> cradr goes to 0x200, then to 0x101; depth goes 1 then 0.
- STACK_DEPTH=16: perform 17 pushes of distinct values, then 16 pops -> stackOverflow=1; pops return values 17 down to 2; depth=0.
- From empty, dispSel=3, j=0x040 -> cradr=0x040 and stackUnderflow=1. Then clrErr -> flag returns to 0.
- With stall=1, call=1, dispSel=1 -> cradr and depth unchanged. Then raise force1777 during the stall -> cradr=0x7FF and depth=0.
- With CRA_STACK_PARITY_EN defined: corrupt one stack bit via force, then pop -> stackParityErr=1, and the popped address is still used.
